regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_rr_arbiter2.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_pkg
// Purpose  : Shared widths and requester-id encoding for the register-file
//            writeback arbiter and its round-robin grant sub-module.
// Contents : c_REG_IDX_W - register index width
//            c_DATA_W    - register data width
//            req_id_e    - requester id (A = ALU writeback, B = load writeback)
// Revision : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

  localparam int c_REG_IDX_W = 5;
  localparam int c_DATA_W    = 32;

  // Bit position of each requester in req/grant vectors matches its id.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin grant. A lone requester is granted directly.
//            Under contention the requester that did not win last is granted.
// Ports    : req[1:0]   - request vector (bit index = requester id)
//            last       - id of the most recently granted requester
//            grant[1:0] - one-hot (or zero) grant vector
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (&req) begin
      grant = 2'b00;
      if (last == REQ_B) begin
        grant[REQ_A] = 1'b1;
      end else begin
        grant[REQ_B] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Merges the ALU (A) and load (B) writeback streams onto the single
//            register-file write port, one write per cycle, round-robin under
//            contention. Write port outputs are registered.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            a_valid/a_rd/a_data/a_ready - requester A handshake
//            b_valid/b_rd/b_data/b_ready - requester B handshake
//            rf_reg_write/rf_rd/rf_write_data - register-file write port
//            last_grant                  - id of most recent grant (0=A,1=B)
//            contention_cnt              - saturating count of contended cycles
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_valid,
  input  logic [c_REG_IDX_W-1:0] a_rd,
  input  logic [c_DATA_W-1:0]    a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [c_REG_IDX_W-1:0] b_rd,
  input  logic [c_DATA_W-1:0]    b_data,
  output logic                   b_ready,
  output logic                   rf_reg_write,
  output logic [c_REG_IDX_W-1:0] rf_rd,
  output logic [c_DATA_W-1:0]    rf_write_data,
  output logic                   last_grant,
  output logic [CNT_W-1:0]       contention_cnt
);

  logic [1:0]             w_req;
  logic [1:0]             w_grant;
  logic                   w_hs;
  logic [c_REG_IDX_W-1:0] w_sel_rd;
  logic [c_DATA_W-1:0]    w_sel_data;
  logic                   w_contend;
  logic                   w_cnt_max;

  logic                   r_we;
  logic [c_REG_IDX_W-1:0] r_rd;
  logic [c_DATA_W-1:0]    r_data;
  logic                   r_last;
  logic [CNT_W-1:0]       r_cnt;

  // Requests are masked by reset so no ready is offered while rst_n is low.
  assign w_req = {b_valid, a_valid} & {2{rst_n}};

  rr_arbiter2 u_rr_arbiter2 (
    .req   (w_req),
    .last  (r_last),
    .grant (w_grant)
  );

  assign a_ready = w_grant[REQ_A];
  assign b_ready = w_grant[REQ_B];

  // A grant is only ever issued to a valid requester, so any grant is a
  // completed handshake.
  assign w_hs       = |w_grant;
  assign w_sel_rd   = w_grant[REQ_B] ? b_rd   : a_rd;
  assign w_sel_data = w_grant[REQ_B] ? b_data : a_data;

  assign w_contend = a_valid & b_valid;
  assign w_cnt_max = &r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
      r_last <= REQ_B;
      r_cnt  <= '0;
    end else begin
      // x0 writes are accepted but never enabled on the register file.
      r_we <= w_hs && (w_sel_rd != '0);
      if (w_hs) begin
        r_rd   <= w_sel_rd;
        r_data <= w_sel_data;
        r_last <= w_grant[REQ_B];
      end
      if (w_contend && !w_cnt_max) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign rf_reg_write   = r_we;
  assign rf_rd          = r_rd;
  assign rf_write_data  = r_data;
  assign last_grant     = r_last;
  assign contention_cnt = r_cnt;

endmodule
`default_nettype wire
